led_scan_driver: RTL and testbench



---
 rtl/led_pkg.sv | 17 +
 rtl/led_dwell_timer.sv | 27 ++
 rtl/led_scan_driver.sv | 115 +++++++++++
 tb/tb_led_scan_driver.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared types and constants for the 16x16 red/green LED matrix path.
package led_pkg;

  localparam int LED_ROWS = 16;
  localparam int LED_COLS = 16;

  typedef logic [LED_COLS-1:0]               led_row_t;
  typedef logic [LED_ROWS-1:0][LED_COLS-1:0] led_frame_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    BLANK = 2'd2,
    DRIVE = 2'd3
  } scan_state_e;

endpackage

// File: rtl/led_dwell_timer.sv
// Loadable down-counter; o_done is high on the last cycle of a dwell.
module led_dwell_timer #(
  parameter int CNT_W = 12
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  output logic             o_done
);

  logic [CNT_W-1:0] r_cnt;

  // Counts down to 1 and holds there until the next load.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt > CNT_W'(1)) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_done = (r_cnt == CNT_W'(1));

endmodule

// File: rtl/led_scan_driver.sv
// Row-multiplexed scan of a snapshotted 16x16 red/green frame onto the
// physical matrix, with a blanking gap before each row.
module led_scan_driver
  import led_pkg::*;
#(
  parameter int ROW_CYCLES   = 2048,
  parameter int BLANK_CYCLES = 16
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        enable,
  input  led_frame_t  red_in,
  input  led_frame_t  green_in,
  output logic [15:0] row_sel,
  output logic [15:0] red_col,
  output logic [15:0] green_col,
  output logic        frame_start,
  output logic [3:0]  row_idx
);

  localparam int MAX_DWELL = (ROW_CYCLES > BLANK_CYCLES) ? ROW_CYCLES : BLANK_CYCLES;
  localparam int CNT_W     = $clog2(MAX_DWELL + 1);

  scan_state_e      r_state;
  led_frame_t       r_shadow_red;
  led_frame_t       r_shadow_green;
  logic             w_done;
  logic             w_load;
  logic [CNT_W-1:0] w_load_val;
  logic             w_last_row;

  assign w_last_row = (row_idx == 4'(LED_ROWS - 1));

  // Timer reloads on the same edge the FSM enters BLANK or DRIVE.
  always_comb begin
    w_load     = 1'b0;
    w_load_val = CNT_W'(BLANK_CYCLES);
    case (r_state)
      LOAD:  w_load = 1'b1;
      BLANK: if (w_done) begin
        w_load     = 1'b1;
        w_load_val = CNT_W'(ROW_CYCLES);
      end
      DRIVE: if (w_done && !w_last_row && enable) w_load = 1'b1;
      default: ;
    endcase
  end

  led_dwell_timer #(.CNT_W(CNT_W)) u_timer (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_done     (w_done)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state        <= IDLE;
      r_shadow_red   <= '0;
      r_shadow_green <= '0;
      row_sel        <= 16'h0000;
      red_col        <= 16'hFFFF;
      green_col      <= 16'hFFFF;
      frame_start    <= 1'b0;
      row_idx        <= 4'd0;
    end else begin
      frame_start <= 1'b0;
      case (r_state)
        IDLE: begin
          row_sel   <= 16'h0000;
          red_col   <= 16'hFFFF;
          green_col <= 16'hFFFF;
          if (enable) begin
            r_state     <= LOAD;
            frame_start <= 1'b1;
            row_idx     <= 4'd0;
          end
        end
        LOAD: begin
          r_shadow_red   <= red_in;
          r_shadow_green <= green_in;
          r_state        <= BLANK;
        end
        BLANK: begin
          if (w_done) begin
            r_state   <= DRIVE;
            row_sel   <= 16'h0001 << row_idx;
            red_col   <= ~r_shadow_red[row_idx];
            green_col <= ~r_shadow_green[row_idx];
          end
        end
        DRIVE: begin
          if (w_done) begin
            row_sel   <= 16'h0000;
            red_col   <= 16'hFFFF;
            green_col <= 16'hFFFF;
            if (!enable) begin
              r_state <= IDLE;
            end else if (!w_last_row) begin
              r_state <= BLANK;
              row_idx <= row_idx + 4'd1;
            end else begin
              r_state     <= LOAD;
              frame_start <= 1'b1;
              row_idx     <= 4'd0;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_led_scan_driver.sv
// Directed bench for led_scan_driver with ROW_CYCLES=4, BLANK_CYCLES=2
// (6 cycles per row, 97 cycles per frame).
module tb_led_scan_driver;

  logic              CLK = 1'b0;
  logic              RST_N;
  logic              enable;
  logic [15:0][15:0] red_in;
  logic [15:0][15:0] green_in;
  logic [15:0]       row_sel;
  logic [15:0]       red_col;
  logic [15:0]       green_col;
  logic              frame_start;
  logic [3:0]        row_idx;

  logic [15:0][15:0] m_red;
  logic [15:0][15:0] m_green;
  int n_cmp = 0;
  int n_err = 0;

  led_scan_driver #(.ROW_CYCLES(4), .BLANK_CYCLES(2)) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .enable      (enable),
    .red_in      (red_in),
    .green_in    (green_in),
    .row_sel     (row_sel),
    .red_col     (red_col),
    .green_col   (green_col),
    .frame_start (frame_start),
    .row_idx     (row_idx)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_off(input string tag);
    chk({tag, ".row_sel"},   row_sel,   16'h0000);
    chk({tag, ".red_col"},   red_col,   16'hFFFF);
    chk({tag, ".green_col"}, green_col, 16'hFFFF);
  endtask

  // LOAD cycle: pulse, row 0, outputs off; bench model snapshots its inputs.
  task automatic chk_load(input string tag);
    chk({tag, ".frame_start"}, {15'd0, frame_start}, 16'h0001);
    chk({tag, ".row_idx"},     {12'd0, row_idx},     16'h0000);
    chk_off(tag);
    m_red   = red_in;
    m_green = green_in;
  endtask

  // Cycle t (1..96) after LOAD: rows occupy 6 cycles, 2 blank then 4 drive.
  task automatic chk_scan(input int t);
    int r;
    int p;
    logic [15:0] one;
    string tag;
    r   = (t - 1) / 6;
    p   = (t - 1) % 6;
    one = 16'h0001;
    tag = $sformatf("t%0d_r%0d", t, r);
    chk({tag, ".frame_start"}, {15'd0, frame_start}, 16'h0000);
    chk({tag, ".row_idx"},     {12'd0, row_idx},     16'(r));
    if (p >= 2) begin
      chk({tag, ".row_sel"},   row_sel,   one << r);
      chk({tag, ".red_col"},   red_col,   ~m_red[r]);
      chk({tag, ".green_col"}, green_col, ~m_green[r]);
    end else begin
      chk_off(tag);
    end
  endtask

  initial begin
    RST_N    = 1'b0;
    enable   = 1'b1;
    red_in   = '0;
    green_in = '0;
    red_in[3] = 16'h0001;

    // Reset held with enable high: everything stays off.
    repeat (3) step();
    chk_off("rst_hold");
    chk("rst_hold.frame_start", {15'd0, frame_start}, 16'h0000);
    chk("rst_hold.row_idx",     {12'd0, row_idx},     16'h0000);
    RST_N = 1'b1;
    #1;
    chk("rst_rel.frame_start", {15'd0, frame_start}, 16'h0000);

    // Frame 1: single red pixel on row 3, then period check.
    step();
    chk_load("f1_load");
    for (int t = 1; t <= 96; t++) begin
      step();
      chk_scan(t);
    end

    // Frame 2: green row 10 changes while row 5 drives; snapshot is unaffected.
    step();
    chk_load("f2_load");
    for (int t = 1; t <= 96; t++) begin
      step();
      chk_scan(t);
      if (t == 33) green_in[10] = 16'hFFFF;
    end
    chk("f2_row10_snap", m_green[10], 16'h0000);

    // Frame 3: the new green row 10 now appears (green_col=0000 on row 10).
    step();
    chk_load("f3_load");
    for (int t = 1; t <= 96; t++) begin
      step();
      chk_scan(t);
    end

    // Frame 4: drop enable mid row 7; row completes, then IDLE.
    step();
    chk_load("f4_load");
    for (int t = 1; t <= 48; t++) begin
      step();
      chk_scan(t);
      if (t == 46) enable = 1'b0;
    end
    for (int i = 0; i < 4; i++) begin
      step();
      chk_off($sformatf("idle%0d", i));
      chk($sformatf("idle%0d.frame_start", i), {15'd0, frame_start}, 16'h0000);
    end
    enable = 1'b1;
    step();
    chk_load("f5_load");

    // Frame 5: async reset during row 12 drive takes effect before the next edge.
    for (int t = 1; t <= 76; t++) begin
      step();
      chk_scan(t);
    end
    #2 RST_N = 1'b0;
    #1;
    chk_off("async_rst");
    chk("async_rst.frame_start", {15'd0, frame_start}, 16'h0000);
    chk("async_rst.row_idx",     {12'd0, row_idx},     16'h0000);
    step();
    RST_N = 1'b1;
    step();
    chk_load("f6_load");
    for (int t = 1; t <= 12; t++) begin
      step();
      chk_scan(t);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
